instr_line_buffer: RTL and testbench

INSTR_LINE_BUFFER -- requirements
Module: instr_line_buffer

---
 rtl/instr_line_buffer.sv | 117 +++++++++++
 tb/tb_instr_line_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_line_buffer.sv
// Single-line instruction buffer: one 256-bit line filled in four 64-bit memory beats.
// Optional hit/miss statistics counters are enabled by defining IMEM_STATS_EN.
module instr_line_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read_i,
    input  logic [31:0] imem_address_i,
    output logic [31:0] imem_rdata_o,
    output logic        imem_resp_o,
    input  logic        flush_i,
    output logic        pmem_read_o,
    output logic [31:0] pmem_address_o,
    input  logic [63:0] pmem_rdata_i,
    input  logic        pmem_resp_i
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [255:0] line;
    logic [26:0]  tag;
    logic         valid;
    logic [1:0]   beat;
    logic [29:0]  addr_q;
    logic         flush_seen;
    logic         hit;
    logic         lookup_hit;
    logic         lookup_miss;

    // A flush in the lookup cycle forces a miss even though valid is still set.
    assign hit         = valid && !flush_i && (tag == imem_address_i[31:5]);
    assign lookup_hit  = (state == IDLE) && imem_read_i && hit;
    assign lookup_miss = (state == IDLE) && imem_read_i && !hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= 1'b0;
            tag        <= 27'd0;
            beat       <= 2'd0;
            addr_q     <= 30'd0;
            flush_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i)
                        valid <= 1'b0;
                    if (imem_read_i) begin
                        addr_q <= imem_address_i[31:2];
                        if (hit) begin
                            state <= DONE;
                        end else begin
                            valid      <= 1'b0;
                            beat       <= 2'd0;
                            flush_seen <= 1'b0;
                            state      <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (flush_i)
                        flush_seen <= 1'b1;
                    if (pmem_resp_i) begin
                        beat <= beat + 2'd1;
                        // A flush seen at any point of the fill installs the line as invalid.
                        if (beat == 2'd3) begin
                            tag   <= addr_q[29:3];
                            valid <= !(flush_seen || flush_i);
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush_i)
                        valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && pmem_resp_i)
            line[{beat, 6'b0} +: 64] <= pmem_rdata_i;
    end

    assign imem_resp_o    = (state == DONE);
    assign imem_rdata_o   = (state == DONE) ? line[{addr_q[2:0], 5'b0} +: 32] : 32'd0;
    assign pmem_read_o    = (state == FILL);
    assign pmem_address_o = (state == FILL) ? {addr_q[29:3], 5'b0} : 32'd0;

`ifdef IMEM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_o  <= 32'd0;
            miss_count_o <= 32'd0;
        end else begin
            if (lookup_hit && hit_count_o != 32'hFFFF_FFFF)
                hit_count_o <= hit_count_o + 32'd1;
            if (lookup_miss && miss_count_o != 32'hFFFF_FFFF)
                miss_count_o <= miss_count_o + 32'd1;
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = lookup_hit ^ lookup_miss;
`endif

endmodule

// File: tb/tb_instr_line_buffer.sv
// Self-checking bench for instr_line_buffer: directed scenarios plus randomized reads
// compared against a line-level reference model (IMEM_STATS_EN adds counter checks).
module tb_instr_line_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read_i;
    logic [31:0] imem_address_i;
    logic [31:0] imem_rdata_o;
    logic        imem_resp_o;
    logic        flush_i;
    logic        pmem_read_o;
    logic [31:0] pmem_address_o;
    logic [63:0] pmem_rdata_i;
    logic        pmem_resp_i;
`ifdef IMEM_STATS_EN
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;
`endif

    instr_line_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .imem_read_i    (imem_read_i),
        .imem_address_i (imem_address_i),
        .imem_rdata_o   (imem_rdata_o),
        .imem_resp_o    (imem_resp_o),
        .flush_i        (flush_i),
        .pmem_read_o    (pmem_read_o),
        .pmem_address_o (pmem_address_o),
        .pmem_rdata_i   (pmem_rdata_i),
        .pmem_resp_i    (pmem_resp_i)
`ifdef IMEM_STATS_EN
        ,
        .hit_count_o    (hit_count_o),
        .miss_count_o   (miss_count_o)
`endif
    );

    always #5 clk = ~clk;

    int pass_count  = 0;
    int check_count = 0;

    // Reference model: what the one-line buffer holds, as eight words plus tag/valid.
    bit          m_valid;
    logic [26:0] m_tag;
    logic [31:0] m_line [8];
    int          m_hits;
    int          m_misses;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_resp"}, 64'(imem_resp_o), 64'd0);
        checkOutput({tag, "_rdata"}, 64'(imem_rdata_o), 64'd0);
        checkOutput({tag, "_pmem_read"}, 64'(pmem_read_o), 64'd0);
        checkOutput({tag, "_pmem_addr"}, 64'(pmem_address_o), 64'd0);
    endtask

    task automatic checkCounters();
`ifdef IMEM_STATS_EN
        checkOutput("hit_count", 64'(hit_count_o), 64'(m_hits));
        checkOutput("miss_count", 64'(miss_count_o), 64'(m_misses));
`endif
    endtask

    // One complete read transaction starting in IDLE; ends back in IDLE.
    task automatic applyStimulus(input logic [31:0] addr, input bit flush, input int gap,
                                 input bit flush_in_fill, input bit stray, input bit fixed);
        logic [63:0] beats [4];
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] line_addr;
        int          w;
        bit          hit;
        w         = int'(addr[4:2]);
        line_addr = {addr[31:5], 5'b0};
        hit       = m_valid && !flush && (m_tag == addr[31:5]);
        imem_read_i    = 1'b1;
        imem_address_i = addr;
        flush_i        = flush;
        tick();
        flush_i = 1'b0;
        if (flush)
            m_valid = 1'b0;
        if (hit) begin
            m_hits++;
            checkOutput("hit_resp", 64'(imem_resp_o), 64'd1);
            checkOutput("hit_data", 64'(imem_rdata_o), 64'(m_line[w]));
            checkOutput("hit_pmem_read", 64'(pmem_read_o), 64'd0);
        end else begin
            m_misses++;
            m_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (fixed) begin
                    lo = 32'h1111_1111 * 32'(2 * k + 1);
                    hi = 32'h1111_1111 * 32'(2 * k + 2);
                end else begin
                    lo = $urandom;
                    hi = $urandom;
                end
                beats[k] = {hi, lo};
            end
            imem_address_i = $urandom;
            imem_read_i    = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                for (int g = 0; g < gap; g++) begin
                    checkOutput("gap_pmem_read", 64'(pmem_read_o), 64'd1);
                    checkOutput("gap_resp", 64'(imem_resp_o), 64'd0);
                    pmem_resp_i  = 1'b0;
                    pmem_rdata_i = {$urandom, $urandom};
                    tick();
                end
                checkOutput("fill_pmem_read", 64'(pmem_read_o), 64'd1);
                checkOutput("fill_pmem_addr", 64'(pmem_address_o), 64'(line_addr));
                checkOutput("fill_resp", 64'(imem_resp_o), 64'd0);
                pmem_resp_i  = 1'b1;
                pmem_rdata_i = beats[k];
                flush_i      = flush_in_fill && (k == 1);
                tick();
                pmem_resp_i = 1'b0;
                flush_i     = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                m_line[2 * k]     = beats[k][31:0];
                m_line[2 * k + 1] = beats[k][63:32];
            end
            m_tag   = addr[31:5];
            m_valid = !flush_in_fill;
            checkOutput("miss_resp", 64'(imem_resp_o), 64'd1);
            checkOutput("miss_data", 64'(imem_rdata_o), 64'(m_line[w]));
            checkOutput("miss_pmem_read", 64'(pmem_read_o), 64'd0);
        end
        imem_read_i = 1'b0;
        tick();
        checkIdle("after_done");
        if (stray) begin
            pmem_resp_i  = 1'b1;
            pmem_rdata_i = {$urandom, $urandom};
            tick();
            pmem_resp_i = 1'b0;
            checkIdle("stray");
        end
        checkCounters();
    endtask

    task automatic applyFlush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        m_valid = 1'b0;
        checkIdle("flush");
    endtask

    initial begin
        logic [31:0] bases [3];
        logic [31:0] a;
        bases[0] = 32'h0000_0060;
        bases[1] = 32'h0000_1000;
        bases[2] = 32'h8000_0020;
        m_valid = 1'b0; m_tag = '0; m_hits = 0; m_misses = 0;
        rst = 1'b1; imem_read_i = 1'b0; imem_address_i = '0; flush_i = 1'b0;
        pmem_rdata_i = '0; pmem_resp_i = 1'b0;
        #1;
        checkIdle("reset");
        checkCounters();
        tick();
        rst = 1'b0;
        tick();
        checkIdle("post_reset");

        // Cold miss, then hits on other words of the same line.
        applyStimulus(32'h0000_0064, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0000_0068, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0000_007C, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Flush then refill with gapped beats and a stray beat afterwards.
        applyFlush();
        applyStimulus(32'h0000_0068, 1'b0, 3, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h0000_0060, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Flush during fill: data still returned, next access misses.
        applyStimulus(32'h0000_1000, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0000_1004, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Reset after two beats of a fill.
        imem_read_i = 1'b1; imem_address_i = 32'h0000_0060;
        tick();
        checkOutput("rfill_pmem_read", 64'(pmem_read_o), 64'd1);
        for (int k = 0; k < 2; k++) begin
            pmem_resp_i = 1'b1; pmem_rdata_i = {$urandom, $urandom};
            tick();
        end
        pmem_resp_i = 1'b0;
        rst = 1'b1;
        #1;
        checkIdle("reset_mid_fill");
        m_valid = 1'b0; m_hits = 0; m_misses = 0;
        checkCounters();
        tick();
        rst = 1'b0; imem_read_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pmem_resp_i = 1'b1; pmem_rdata_i = {$urandom, $urandom};
            tick();
            checkIdle("late_beat");
        end
        pmem_resp_i = 1'b0;
        applyStimulus(32'h0000_0060, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic over a few lines.
        for (int i = 0; i < 40; i++) begin
            a = bases[$urandom_range(0, 2)] | {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0)
                applyFlush();
            applyStimulus(a, $urandom_range(0, 7) == 0, $urandom_range(0, 3),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
